kernel_pio_edge: RTL



---
 rtl/kernel_pio_pkg.sv | 28 ++
 rtl/kernel_pio_sync.sv | 58 +++++
 rtl/kernel_pio_edge.sv | 126 ++++++++++++
 3 files changed

// File: rtl/kernel_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pio_pkg
// Description : Register map and encoding constants for the edge-capable PIO.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_pio_pkg;

    // Word addresses of the slave register map; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_DIR      = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLEAR = 3'd5
    } pio_addr_e;

    localparam int EDGE_NONE = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;
    localparam int EDGE_ANY  = 3;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage : kernel_pio_pkg
`default_nettype wire

// File: rtl/kernel_pio_sync.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pio_sync
// Description : Input synchroniser chain, one-cycle history and edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_pio_sync
    import kernel_pio_pkg::*;
#(
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign data_sync = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_det = data_sync & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = ~data_sync & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_det = data_sync ^ prev_q;
        end else begin : g_none
            logic w_unused_prev;
            assign w_unused_prev = ^prev_q;
            assign edge_det      = '0;
        end
    endgenerate

endmodule : kernel_pio_sync
`default_nettype wire

// File: rtl/kernel_pio_edge.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pio_edge
// Description : Avalon-MM bidirectional PIO with edge capture and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_pio_edge
    import kernel_pio_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_MODE    = IRQ_LEVEL,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_data_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_rd_sel;
    logic             w_irq_src;
    logic             w_unused_wd;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] dir_q,      dir_d;
    logic [WIDTH-1:0] mask_q,     mask_d;
    logic [WIDTH-1:0] cap_q,      cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q,      irq_d;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    kernel_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .in_port   (in_port),
        .data_sync (w_data_sync),
        .edge_det  (w_edge)
    );

    always_comb begin
        out_data_d = out_data_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        w_clear    = '0;
        if (w_wr) begin
            case (address)
                ADDR_DATA:     out_data_d = w_wd;
                ADDR_DIR:      dir_d      = w_wd;
                ADDR_IRQ_MASK: mask_d     = w_wd;
                ADDR_EDGE_CAP: w_clear    = w_wd;
                ADDR_OUTSET:   out_data_d = out_data_q | w_wd;
                ADDR_OUTCLEAR: out_data_d = out_data_q & ~w_wd;
                default:       ;
            endcase
        end
        // A fresh edge overrides a simultaneous write-1-to-clear.
        cap_d = (cap_q & ~w_clear) | w_edge;
    end

    always_comb begin
        w_rd_sel = '0;
        case (address)
            ADDR_DATA:     w_rd_sel = w_data_sync;
            ADDR_DIR:      w_rd_sel = dir_q;
            ADDR_IRQ_MASK: w_rd_sel = mask_q;
            ADDR_EDGE_CAP: w_rd_sel = cap_q;
            default:       w_rd_sel = '0;
        endcase
        readdata_d = 32'(w_rd_sel);
        irq_d      = w_irq_src;
    end

    generate
        if (IRQ_MODE == IRQ_EDGE) begin : g_irq_edge
            assign w_irq_src = |(cap_q & mask_q);
        end else begin : g_irq_level
            assign w_irq_src = |(w_data_sync & mask_q);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= RESET_VALUE;
            dir_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_data_q;
    assign oe       = dir_q;
    assign irq      = irq_q;

endmodule : kernel_pio_edge
`default_nettype wire
